errbit_frame_serializer: RTL and testbench
==========================================

Name: errbit_frame_serializer

Overview:
- Parametrised, re-arming successor to the single-shot error-bit packer.
- Collects error-bit words from NSRC front-end sources after a trigger, bounded by a programmable timeout.
- Serialises one framed bit-stream per trigger on a single output line toward the back-end link, then returns to idle for the next trigger.
- Adds a lost-trigger counter, busy and done status, and an optional parity trailer.

Parameters:
- NSRC, 2, number of error-bit sources (1..8).
- EW, 11, error-bit word width per source; narrower sources tie their unused MSBs to 1.
- TW, 9, timeout counter width.
- LW, 8, lost-trigger counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- live  in  1  run enable; low forces synchronous abort to IDLE.
- trig_align  in  1  aligned trigger pulse.
- maxt  in  TW  timeout in cycles after trigger.
- dv  in  NSRC  per-source data valid.
- errbit  in  NSRC*EW  flat error words; source i occupies bits [i*EW +: EW].
- q  out  1  serial frame output.
- busy  out  1  high in WAIT or SEND.
- frame_done  out  1  one-cycle pulse after the last frame bit.
- trig_lost  out  LW  saturating count of triggers ignored during SEND.

Behaviour:
- Reset (rst=1, has priority over live) sets:
  - state=IDLE, q=0, busy=0, frame_done=0, trig_lost=0, timer=0, bit index=0.
  - All got[i]=0 and all word registers to all-ones.
- live=0 has the same effect as reset, except trig_lost is held.
- Frame order, LSB first within each field, length L = 3 + NSRC + NSRC*EW (+1 with parity):
  - Header 1,0,1.
  - got[0..NSRC-1].
  - Word 0 bits 0..EW-1, then word 1, and so on.
- Capture, in IDLE and WAIT only: dv[i]=1 loads word i and sets got[i]. A repeated dv overwrites the word (last wins). dv in SEND is ignored.
- IDLE:
  - trig_align=1 goes to WAIT with timer=0.
  - If the captures of this edge complete the set (all got), go directly to SEND, even with no trigger.
- WAIT:
  - All got, including completion on this edge, goes to SEND.
  - Else, if timer==maxt, go to SEND (timeout, missing sources send got=0 and all-ones words).
  - Else timer increments.
  - trig_align in WAIT is ignored and not counted.
- Entering SEND:
  - The frame is snapshotted on the same edge; the registered q carries bit 0 in the following cycle.
  - Each subsequent cycle emits the next bit.
- Latency:
  - Completing dv in cycle c gives q=bit0 in cycle c+1.
  - Trigger in cycle t with no data gives q=bit0 in cycle t+maxt+2 (maxt=0 gives t+2).
- SEND:
  - After bit L-1, the next cycle has q=0, frame_done=1, state=IDLE.
  - got and word registers are cleared to their reset values on that edge.
- q is 0 whenever state is not SEND.
- busy=1 in WAIT and SEND.
- trig_align=1 in SEND increments trig_lost, saturating at all-ones.
- Trigger in the frame_done cycle (state IDLE) is accepted normally.
- Simultaneous trigger and final dv in IDLE: completion wins, go to SEND and do not count the trigger.
- timer is TW bits wide; maxt all-ones is legal and gives no wrap because the compare occurs before increment.

Optional Feature:
- ERRPACK_PARITY_EN
- Defined: one trailer bit is appended as bit L-1. It is the even parity (XOR) over all preceding frame bits, header included.
- Undefined: no trailer; L = 3 + NSRC + NSRC*EW.

Decomposition:
- Package errpack_pkg holds:
  - State enum IDLE/WAIT/SEND.
  - HEADER constant 3'b101.
  - Frame-length function of NSRC/EW/parity.
  - Localparam for bit-index width (clog2 of L).
- One natural sub-module, errpack_shift_out: loads the L-bit snapshot and shifts it LSB-first with a done strobe.
- Capture logic and the FSM stay in the top module.

Test Plan:
- NSRC=2, EW=11, maxt=20:
  - Stimulus: trigger at t=0; dv[0] with 0x2A5 at t=3; dv[1] with 0x013 at t=5.
  - Response: q=1,0,1,1,1 from t=6, then 0x2A5 and 0x013 LSB-first; frame_done at t=6+L; busy high t=1..t+L.
- Timeout, maxt=4:
  - Stimulus: trigger at t=0; only dv[1]=0x7FF.
  - Response: bit0 at t=6; got field 0,1; word 0 all-ones.
- dv before trigger:
  - Stimulus: dv[0] at t=0, dv[1] at t=2, no trigger.
  - Response: frame starts t=3.
- Triggers during SEND:
  - Stimulus: 3 triggers in SEND.
  - Response: trig_lost=3; no second frame; a trigger in the frame_done cycle starts a new WAIT.
  - Also force saturation at LW=2 and check the count holds at 3.
- Abort and reset:
  - Stimulus: live=0 mid-SEND.
  - Response: q=0 next cycle; state IDLE; trig_lost held. rst in the same cycle clears trig_lost.
- With ERRPACK_PARITY_EN:
  - Stimulus: words 0x001 and 0x000, both present.
  - Response: parity bit = XOR(1,0,1,1,1,1) = 1.

Source files
------------

// File: rtl/errpack_pkg.sv
// Shared types and frame-geometry helpers for the error-bit frame serializer.
// ERRPACK_PARITY_EN appends an even-parity trailer bit to every frame.
package errpack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    // Sent LSB first, so the wire sees 1,0,1.
    localparam logic [2:0] HEADER = 3'b101;

`ifdef ERRPACK_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int nsrc, input int ew, input int parity);
        return 3 + nsrc + nsrc * ew + parity;
    endfunction

    localparam int DEF_FRAME_LEN = frame_len(2, 11, PARITY_BITS);
    localparam int DEF_IDX_W     = $clog2(DEF_FRAME_LEN);

endpackage

// File: rtl/errpack_shift_out.sv
// Loads an L-bit frame snapshot and shifts it out LSB first on a registered line,
// strobing done in the cycle after the last bit.
module errpack_shift_out #(
    parameter int L  = 27,
    parameter int IW = $clog2(L)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [L-1:0] frame,
    output logic         q,
    output logic         last,
    output logic         done
);

    logic [L-1:0]  shreg;
    logic [IW-1:0] idx;
    logic          active;

    // High during the cycle that carries bit L-1 on q.
    assign last = active && (idx == IW'(L - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg  <= '0;
            idx    <= '0;
            active <= 1'b0;
            q      <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shreg  <= frame >> 1;
                idx    <= '0;
                active <= 1'b1;
                q      <= frame[0];
            end else if (last) begin
                active <= 1'b0;
                idx    <= '0;
                q      <= 1'b0;
                done   <= 1'b1;
            end else if (active) begin
                q     <= shreg[0];
                shreg <= shreg >> 1;
                idx   <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/errbit_frame_serializer.sv
// Collects per-source error words after a trigger (or on full capture) and sends one
// framed serial bit-stream per trigger. ERRPACK_PARITY_EN adds a parity trailer bit.
module errbit_frame_serializer
    import errpack_pkg::*;
#(
    parameter int NSRC = 2,
    parameter int EW   = 11,
    parameter int TW   = 9,
    parameter int LW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               live,
    input  logic               trig_align,
    input  logic [TW-1:0]      maxt,
    input  logic [NSRC-1:0]    dv,
    input  logic [NSRC*EW-1:0] errbit,
    output logic               q,
    output logic               busy,
    output logic               frame_done,
    output logic [LW-1:0]      trig_lost
);

    localparam int BL = 3 + NSRC + NSRC * EW;
    localparam int L  = frame_len(NSRC, EW, PARITY_BITS);
    localparam int IW = $clog2(L);

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [NSRC-1:0] got;
    logic [NSRC-1:0] got_next;
    logic [EW-1:0]   words      [NSRC];
    logic [EW-1:0]   words_next [NSRC];
    logic [BL-1:0]   body;
    logic [L-1:0]    frame;
    logic            all_got;
    logic            last;
    logic            load;
    logic            finish_frame;

    // Captures on this edge are visible to the completion test and the snapshot.
    always_comb begin
        got_next = got;
        for (int i = 0; i < NSRC; i++) begin
            words_next[i] = words[i];
            if (dv[i] && (state != SEND)) begin
                got_next[i]   = 1'b1;
                words_next[i] = errbit[i*EW +: EW];
            end
        end
    end

    assign all_got = &got_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (all_got)         state_next = SEND;
                else if (trig_align) state_next = WAIT;
            end
            WAIT: begin
                if (all_got || (timer == maxt)) state_next = SEND;
            end
            SEND: begin
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign load         = (state != SEND) && (state_next == SEND);
    assign finish_frame = (state == SEND) && last;

    always_comb begin
        body = '0;
        body[2:0] = HEADER;
        body[3 +: NSRC] = got_next;
        for (int i = 0; i < NSRC; i++) begin
            body[3 + NSRC + i*EW +: EW] = words_next[i];
        end
    end

`ifdef ERRPACK_PARITY_EN
    assign frame = {^body, body};
`else
    assign frame = body;
`endif

    always_ff @(posedge clk) begin
        if (rst || !live) state <= IDLE;
        else              state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst || !live) begin
            timer <= '0;
            got   <= '0;
            for (int i = 0; i < NSRC; i++) words[i] <= '1;
        end else begin
            // Compare-before-increment: maxt all-ones never needs the timer to wrap.
            if ((state == WAIT) && (state_next == WAIT)) timer <= timer + 1'b1;
            else                                         timer <= '0;
            if (finish_frame) begin
                got <= '0;
                for (int i = 0; i < NSRC; i++) words[i] <= '1;
            end else begin
                got <= got_next;
                for (int i = 0; i < NSRC; i++) words[i] <= words_next[i];
            end
        end
    end

    // An abort holds the lost count; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_lost <= '0;
        end else if (live && (state == SEND) && trig_align && (trig_lost != '1)) begin
            trig_lost <= trig_lost + 1'b1;
        end
    end

    always_comb begin
        busy = (state == WAIT) || (state == SEND);
    end

    errpack_shift_out #(
        .L  (L),
        .IW (IW)
    ) u_shift_out (
        .clk   (clk),
        .rst   (rst),
        .clear (!live),
        .load  (load),
        .frame (frame),
        .q     (q),
        .last  (last),
        .done  (frame_done)
    );

endmodule

// File: tb/tb_errbit_frame_serializer.sv
// Randomized and directed bench for errbit_frame_serializer against an event-level frame model.
module tb_errbit_frame_serializer;

    localparam int NSRC = 2;
    localparam int EW   = 11;
    localparam int TW   = 9;
    localparam int LW   = 8;
`ifdef ERRPACK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN = 3 + NSRC + NSRC * EW + PAR;
    localparam int HZ  = 640;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               live = 1'b1;
    logic               trig_align = 1'b0;
    logic [TW-1:0]      maxt = '0;
    logic [NSRC-1:0]    dv = '0;
    logic [NSRC*EW-1:0] errbit = '0;
    logic               q, busy, frame_done;
    logic [LW-1:0]      trig_lost;
    logic               q_s, busy_s, done_s;
    logic [1:0]         trig_lost_s;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_lost = 0;

    logic               sc_trig [HZ];
    logic [NSRC-1:0]    sc_dv   [HZ];
    logic [NSRC*EW-1:0] sc_eb   [HZ];

    always #5 clk = ~clk;

    errbit_frame_serializer #(.NSRC(NSRC), .EW(EW), .TW(TW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .live(live), .trig_align(trig_align), .maxt(maxt),
        .dv(dv), .errbit(errbit), .q(q), .busy(busy), .frame_done(frame_done),
        .trig_lost(trig_lost)
    );

    errbit_frame_serializer #(.NSRC(NSRC), .EW(EW), .TW(TW), .LW(2)) dut_sat (
        .clk(clk), .rst(rst), .live(live), .trig_align(trig_align), .maxt(maxt),
        .dv(dv), .errbit(errbit), .q(q_s), .busy(busy_s), .frame_done(done_s),
        .trig_lost(trig_lost_s)
    );

    // Frame as defined on the wire: header 1,0,1, got flags, words LSB first, optional parity.
    function automatic logic [LEN-1:0] make_frame(input logic [NSRC-1:0] g,
                                                  input logic [NSRC*EW-1:0] w);
        logic [LEN-1:0] f;
        logic p;
        f = '0;
        f[0] = 1'b1;
        f[1] = 1'b0;
        f[2] = 1'b1;
        for (int i = 0; i < NSRC; i++) f[3 + i] = g[i];
        for (int k = 0; k < NSRC * EW; k++) f[3 + NSRC + k] = w[k];
        if (PAR == 1) begin
            p = 1'b0;
            for (int k = 0; k < LEN - 1; k++) p = p ^ f[k];
            f[LEN-1] = p;
        end
        return f;
    endfunction

    task automatic clear_sc();
        for (int t = 0; t < HZ; t++) begin
            sc_trig[t] = 1'b0;
            sc_dv[t]   = '0;
            sc_eb[t]   = '0;
        end
    endtask

    // Plays the scenario tables from cycle 0 (t0 = first trigger, >= HZ when none)
    // and checks q/busy/frame_done every cycle plus the lost counters at the end.
    task automatic run_scenario(input string name, input int mt, input int t0);
        int first, cmax, c, load, bstart, sat, full;
        bit all_src;
        logic [NSRC-1:0] g;
        logic [NSRC*EW-1:0] w;
        logic [LEN-1:0] fb;
        logic eq, ed, eb;
        all_src = 1'b1;
        cmax = 0;
        for (int i = 0; i < NSRC; i++) begin
            first = -1;
            for (int t = 0; t < HZ; t++) if (first < 0 && sc_dv[t][i]) first = t;
            if (first < 0) all_src = 1'b0;
            else if (first > cmax) cmax = first;
        end
        c = all_src ? cmax : 100000;
        if (c <= t0) load = c;
        else         load = (c < t0 + mt + 1) ? c : t0 + mt + 1;
        g = '0;
        w = '1;
        for (int t = 0; t <= load; t++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (sc_dv[t][i]) begin
                    g[i] = 1'b1;
                    w[i*EW +: EW] = sc_eb[t][i*EW +: EW];
                end
            end
        end
        fb = make_frame(g, w);
        bstart = ((load < t0) ? load : t0) + 1;
        maxt = TW'(mt);
        for (int t = 0; t <= load + LEN + 2; t++) begin
            trig_align = sc_trig[t];
            dv = sc_dv[t];
            errbit = sc_eb[t];
            @(negedge clk);
            eq = (t >= load + 1 && t <= load + LEN) ? fb[t - load - 1] : 1'b0;
            ed = (t == load + LEN + 1);
            eb = (t >= bstart && t <= load + LEN);
            n_cmp++;
            if (q !== eq) begin
                n_bad++;
                $display("FAIL %s q t=%0d got %b exp %b", name, t, q, eq);
            end
            n_cmp++;
            if (frame_done !== ed) begin
                n_bad++;
                $display("FAIL %s frame_done t=%0d got %b exp %b", name, t, frame_done, ed);
            end
            n_cmp++;
            if (busy !== eb) begin
                n_bad++;
                $display("FAIL %s busy t=%0d got %b exp %b", name, t, busy, eb);
            end
            if (sc_trig[t] && t >= load + 1 && t <= load + LEN) exp_lost++;
            @(posedge clk);
            #1;
        end
        trig_align = 1'b0;
        dv = '0;
        errbit = '0;
        full = (exp_lost > 255) ? 255 : exp_lost;
        sat = (exp_lost > 3) ? 3 : exp_lost;
        n_cmp++;
        if (trig_lost !== LW'(full)) begin
            n_bad++;
            $display("FAIL %s trig_lost got %0d exp %0d", name, trig_lost, full);
        end
        n_cmp++;
        if (trig_lost_s !== 2'(sat)) begin
            n_bad++;
            $display("FAIL %s trig_lost_sat got %0d exp %0d", name, trig_lost_s, sat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        live = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({q, busy, frame_done} !== 3'b000 || trig_lost !== '0 || trig_lost_s !== '0) begin
            n_bad++;
            $display("FAIL reset outputs got q=%b busy=%b done=%b lost=%0d/%0d exp all 0",
                     q, busy, frame_done, trig_lost, trig_lost_s);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_lost = 0;
    endtask

    task automatic test_basic();
        clear_sc();
        sc_trig[0] = 1'b1;
        sc_dv[3] = 2'b01;
        sc_eb[3][10:0] = 11'h2A5;
        sc_dv[5] = 2'b10;
        sc_eb[5][21:11] = 11'h013;
        run_scenario("basic", 20, 0);
    endtask

    task automatic test_timeout();
        clear_sc();
        sc_trig[0] = 1'b1;
        sc_dv[2] = 2'b10;
        sc_eb[2][21:11] = 11'h7FF;
        run_scenario("timeout", 4, 0);
    endtask

    task automatic test_dv_before_trigger();
        clear_sc();
        sc_dv[0] = 2'b01;
        sc_eb[0][10:0] = 11'h155;
        sc_dv[2] = 2'b10;
        sc_eb[2][21:11] = 11'h0F0;
        run_scenario("dv_no_trig", 7, HZ);
    endtask

    task automatic test_parity_pattern();
        clear_sc();
        sc_dv[0] = 2'b11;
        sc_eb[0][10:0] = 11'h001;
        sc_eb[0][21:11] = 11'h000;
        run_scenario("parity_pattern", 3, HZ);
    endtask

    task automatic test_max_timeout();
        clear_sc();
        sc_trig[0] = 1'b1;
        sc_dv[300] = 2'b01;
        sc_eb[300][10:0] = 11'h3C3;
        run_scenario("max_timeout", (1 << TW) - 1, 0);
    endtask

    task automatic test_lost();
        clear_sc();
        sc_dv[0] = 2'b11;
        sc_eb[0] = 22'($urandom);
        sc_trig[2] = 1'b1;
        sc_trig[5] = 1'b1;
        sc_trig[9] = 1'b1;
        run_scenario("lost_three", 6, HZ);
        clear_sc();
        sc_dv[0] = 2'b11;
        sc_eb[0] = 22'($urandom);
        sc_trig[1] = 1'b1;
        sc_trig[3] = 1'b1;
        run_scenario("lost_saturate", 6, HZ);
    endtask

    task automatic test_trig_in_done();
        logic [NSRC*EW-1:0] w;
        logic [LEN-1:0] f1, f2;
        logic eq, ed, eb;
        w = 22'($urandom);
        f1 = make_frame(2'b11, w);
        f2 = make_frame(2'b00, '1);
        maxt = '0;
        for (int t = 0; t <= 2 * LEN + 4; t++) begin
            dv = (t == 0) ? 2'b11 : 2'b00;
            errbit = (t == 0) ? w : '0;
            trig_align = (t == LEN + 1);
            @(negedge clk);
            if (t >= 1 && t <= LEN)                eq = f1[t - 1];
            else if (t >= LEN + 3 && t <= 2*LEN+2) eq = f2[t - LEN - 3];
            else                                   eq = 1'b0;
            ed = (t == LEN + 1) || (t == 2 * LEN + 3);
            eb = (t >= 1 && t <= LEN) || (t >= LEN + 2 && t <= 2 * LEN + 2);
            n_cmp++;
            if (q !== eq) begin
                n_bad++;
                $display("FAIL trig_in_done q t=%0d got %b exp %b", t, q, eq);
            end
            n_cmp++;
            if (frame_done !== ed || busy !== eb) begin
                n_bad++;
                $display("FAIL trig_in_done status t=%0d got done=%b busy=%b exp done=%b busy=%b",
                         t, frame_done, busy, ed, eb);
            end
            @(posedge clk);
            #1;
        end
        trig_align = 1'b0;
    endtask

    task automatic test_random();
        int mt, t0, nev, tt;
        for (int it = 0; it < 8; it++) begin
            clear_sc();
            for (int t = 0; t < HZ; t++) sc_eb[t] = 22'($urandom);
            mt = $urandom_range(0, 15);
            t0 = $urandom_range(0, 3);
            sc_trig[t0] = 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                nev = $urandom_range(0, 2);
                for (int e = 0; e < nev; e++) begin
                    tt = $urandom_range(0, 25);
                    sc_dv[tt][i] = 1'b1;
                end
            end
            nev = $urandom_range(0, 3);
            for (int e = 0; e < nev; e++) begin
                tt = $urandom_range(t0 + 1, 25);
                sc_trig[tt] = 1'b1;
            end
            run_scenario($sformatf("random%0d", it), mt, t0);
        end
    endtask

    task automatic test_abort_reset();
        logic [NSRC*EW-1:0] w;
        logic [LEN-1:0] fb;
        logic eq;
        int full, sat;
        w = 22'($urandom);
        fb = make_frame(2'b11, w);
        maxt = '0;
        for (int t = 0; t <= 7; t++) begin
            dv = (t == 0) ? 2'b11 : 2'b00;
            errbit = (t == 0) ? w : '0;
            trig_align = (t == 2);
            live = (t != 4);
            @(negedge clk);
            eq = (t >= 1 && t <= 4) ? fb[t - 1] : 1'b0;
            n_cmp++;
            if (q !== eq) begin
                n_bad++;
                $display("FAIL abort q t=%0d got %b exp %b", t, q, eq);
            end
            if (t >= 5) begin
                n_cmp++;
                if (busy !== 1'b0 || frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort idle t=%0d got busy=%b done=%b exp 0 0", t, busy, frame_done);
                end
            end
            if (t == 2) exp_lost++;
            @(posedge clk);
            #1;
        end
        live = 1'b1;
        trig_align = 1'b0;
        full = (exp_lost > 255) ? 255 : exp_lost;
        sat = (exp_lost > 3) ? 3 : exp_lost;
        n_cmp++;
        if (trig_lost !== LW'(full) || trig_lost_s !== 2'(sat)) begin
            n_bad++;
            $display("FAIL abort_hold trig_lost got %0d/%0d exp %0d/%0d", trig_lost, trig_lost_s, full, sat);
        end
        // A partial capture followed by an abort must not leak into the next frame.
        fb = make_frame(2'b00, '1);
        for (int t = 0; t <= LEN + 6; t++) begin
            dv = (t == 0) ? 2'b01 : 2'b00;
            errbit = (t == 0) ? 22'($urandom) : '0;
            live = (t != 1);
            trig_align = (t == 2);
            @(negedge clk);
            eq = (t >= 4 && t <= LEN + 3) ? fb[t - 4] : 1'b0;
            n_cmp++;
            if (q !== eq || frame_done !== (t == LEN + 4)) begin
                n_bad++;
                $display("FAIL abort_clear t=%0d got q=%b done=%b exp q=%b done=%b",
                         t, q, frame_done, eq, (t == LEN + 4));
            end
            @(posedge clk);
            #1;
        end
        trig_align = 1'b0;
        dv = '0;
        rst = 1'b1;
        live = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        live = 1'b1;
        exp_lost = 0;
        @(negedge clk);
        n_cmp++;
        if (trig_lost !== '0 || trig_lost_s !== '0 || q !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_with_abort got lost=%0d/%0d q=%b busy=%b exp 0/0 0 0",
                     trig_lost, trig_lost_s, q, busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_dv_before_trigger();
        test_parity_pattern();
        test_lost();
        test_trig_in_done();
        test_max_timeout();
        test_random();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
